// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-32 control path: FSM states,
// instruction opcodes, ALUOp codes and datapath mux select values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11
  } ctrl_state_e;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] SLTI  = 6'b001010;

  // ALUOp codes, shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // States that hold a memory request open until mem_ready
  function automatic logic isMemState(ctrl_state_e s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state spends waiting for mem_ready and flags a
// timeout once the count reaches MAX_WAIT (MAX_WAIT = 0 never times out).
// A ready in the timeout cycle suppresses the timeout.
module mem_wait_timer #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] MaxCount = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] count_q, count_d;
  logic              waiting;

  // Timeout compare and count update; any cycle that is not a plain wait clears the count
  always_comb begin
    timeout_o = (MAX_WAIT != 0) && active_i && !ready_i && (count_q == MaxCount);
    waiting   = active_i && !ready_i && !timeout_o;
    count_d   = '0;
    if (waiting) begin
      count_d = (count_q == {WAIT_W{1'b1}}) ? count_q : count_q + WAIT_W'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-32 datapath. Moore outputs are
// decoded from the state register, qualified only by mem_ready, jr and the
// memory wait timeout. The opcode is captured in DECODE so later IR changes
// do not disturb the rest of the instruction.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_cond_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       set_less,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state_o,
  output logic       mem_error,
  output logic       illegal_op
);

  ctrl_state_e state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic        timeout;

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .active_i (isMemState(state_q)),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  assign state_o = state_q;

  // Next-state and output decode; reset forces every strobe and select low
  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    mem_to_reg       = 1'b0;
    set_less         = 1'b0;
    reg_dst          = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = SRCB_REG;
    alu_op           = ALUOP_ADD;
    pc_source        = PCSRC_ALU;
    mem_error        = 1'b0;
    illegal_op       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = !timeout;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          mem_error = 1'b1;
          state_d   = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        opcode_d  = opcode;
        case (opcode)
          RTYPE:      state_d = R_EXEC;
          LW, SW:     state_d = MEM_ADDR;
          BEQ, BNE:   state_d = BRANCH;
          J:          state_d = JUMP;
          ADDI, SLTI: state_d = IMM_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode_q == LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        i_or_d   = 1'b1;
        mem_read = !timeout;
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          mem_error = 1'b1;
          state_d   = FETCH;
        end
      end
      MEM_WRITE: begin
        i_or_d    = 1'b1;
        mem_write = !timeout;
        if (mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          mem_error = 1'b1;
          state_d   = FETCH;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        if (jr) begin
          pc_write  = 1'b1;
          pc_source = PCSRC_REG;
          state_d   = FETCH;
        end else begin
          state_d = R_WB;
        end
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a        = 1'b1;
        alu_op           = ALUOP_SUB;
        pc_source        = PCSRC_ALUOUT;
        pc_write_cond    = (opcode_q == BEQ);
        pc_write_cond_ne = (opcode_q == BNE);
        state_d          = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = FETCH;
      end
      IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode_q == SLTI) ? ALUOP_SUB : ALUOP_ADD;
        state_d   = IMM_WB;
      end
      IMM_WB: begin
        reg_write = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode_q == SLTI) ? ALUOP_SUB : ALUOP_ADD;
        set_less  = (opcode_q == SLTI);
        state_d   = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (reset) begin
      state_d          = FETCH;
      opcode_d         = '0;
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      i_or_d           = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      mem_to_reg       = 1'b0;
      set_less         = 1'b0;
      reg_dst          = 1'b0;
      reg_write        = 1'b0;
      alu_src_a        = 1'b0;
      alu_src_b        = SRCB_REG;
      alu_op           = ALUOP_ADD;
      pc_source        = PCSRC_ALU;
      mem_error        = 1'b0;
      illegal_op       = 1'b0;
    end
  end

  // State and latched-opcode registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into a per-cycle plan (state, expected outputs, inputs to drive) from the
// instruction's step sequence and its memory wait counts, then replayed.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int MaxWait = 4;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcWriteCondNe;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       setLess;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       memError;
    logic       illegalOp;
  } outsT;

  typedef struct {
    ctrl_state_e st;
    outsT        outs;
    logic        rdy;
    logic        jrIn;
    logic [5:0]  opIn;
    logic        rst;
  } stepT;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       jr;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_write_cond_ne, i_or_d;
  logic       mem_read, mem_write, ir_write, mem_to_reg, set_less;
  logic       reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
  logic       mem_error, illegal_op;

  outsT obs;
  stepT plan[$];
  int   total = 0;
  int   bad   = 0;

  multicycle_control #(
    .MAX_WAIT(MaxWait),
    .WAIT_W  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode          (opcode),
    .jr              (jr),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .pc_write_cond   (pc_write_cond),
    .pc_write_cond_ne(pc_write_cond_ne),
    .i_or_d          (i_or_d),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ir_write        (ir_write),
    .mem_to_reg      (mem_to_reg),
    .set_less        (set_less),
    .reg_dst         (reg_dst),
    .reg_write       (reg_write),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .alu_op          (alu_op),
    .pc_source       (pc_source),
    .state_o         (state_o),
    .mem_error       (mem_error),
    .illegal_op      (illegal_op)
  );

  assign obs = {pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, set_less, reg_dst, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_source, mem_error, illegal_op};

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic rndBit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rndOp();
    return 6'($urandom);
  endfunction

  function automatic void addStep(ctrl_state_e st, outsT o, logic rdy, logic jrIn, logic [5:0] opIn);
    stepT s;
    s.st   = st;
    s.outs = o;
    s.rdy  = rdy;
    s.jrIn = jrIn;
    s.opIn = opIn;
    s.rst  = 1'b0;
    plan.push_back(s);
  endfunction

  // A memory step: waits up to MaxWait cycles, completes on ready, else times out
  function automatic bit addMemPhase(ctrl_state_e st, outsT pending, outsT done, int waitCycles, logic [5:0] opIn);
    outsT t;
    int   n;
    n = (waitCycles <= MaxWait) ? waitCycles : MaxWait;
    for (int i = 0; i < n; i++) addStep(st, pending, 1'b0, rndBit(), opIn);
    if (waitCycles <= MaxWait) begin
      addStep(st, done, 1'b1, rndBit(), opIn);
      return 1'b1;
    end
    t          = pending;
    t.memRead  = 1'b0;
    t.memWrite = 1'b0;
    t.memError = 1'b1;
    addStep(st, t, 1'b0, rndBit(), opIn);
    return 1'b0;
  endfunction

  function automatic void planInstr(logic [5:0] op, logic jrv, int fWait, int mWait);
    outsT o, pending, done;
    bit   ok;
    pending         = '0;
    pending.memRead = 1'b1;
    pending.aluSrcB = 2'b01;
    done            = pending;
    done.irWrite    = 1'b1;
    done.pcWrite    = 1'b1;
    ok = addMemPhase(FETCH, pending, done, fWait, op);
    if (!ok) return;

    o         = '0;
    o.aluSrcB = 2'b11;
    if (!(op inside {RTYPE, LW, SW, BEQ, BNE, J, ADDI, SLTI})) begin
      o.illegalOp = 1'b1;
      addStep(DECODE, o, rndBit(), rndBit(), op);
      return;
    end
    addStep(DECODE, o, rndBit(), rndBit(), op);

    o = '0;
    if (op == RTYPE) begin
      o.aluSrcA = 1'b1;
      o.aluOp   = 2'b10;
      if (jrv) begin
        o.pcWrite  = 1'b1;
        o.pcSource = 2'b11;
        addStep(R_EXEC, o, rndBit(), 1'b1, rndOp());
      end else begin
        addStep(R_EXEC, o, rndBit(), 1'b0, rndOp());
        o          = '0;
        o.regWrite = 1'b1;
        o.regDst   = 1'b1;
        o.aluOp    = 2'b10;
        addStep(R_WB, o, rndBit(), rndBit(), rndOp());
      end
    end else if (op == LW || op == SW) begin
      o.aluSrcA = 1'b1;
      o.aluSrcB = 2'b10;
      addStep(MEM_ADDR, o, rndBit(), rndBit(), rndOp());
      pending      = '0;
      pending.iOrD = 1'b1;
      if (op == LW) pending.memRead = 1'b1;
      else          pending.memWrite = 1'b1;
      ok = addMemPhase((op == LW) ? MEM_READ : MEM_WRITE, pending, pending, mWait, rndOp());
      if (op == LW && ok) begin
        o          = '0;
        o.regWrite = 1'b1;
        o.memToReg = 1'b1;
        addStep(MEM_WB, o, rndBit(), rndBit(), rndOp());
      end
    end else if (op == BEQ || op == BNE) begin
      o.aluSrcA       = 1'b1;
      o.aluOp         = 2'b01;
      o.pcSource      = 2'b01;
      o.pcWriteCond   = (op == BEQ);
      o.pcWriteCondNe = (op == BNE);
      addStep(BRANCH, o, rndBit(), rndBit(), rndOp());
    end else if (op == J) begin
      o.pcWrite  = 1'b1;
      o.pcSource = 2'b10;
      addStep(JUMP, o, rndBit(), rndBit(), rndOp());
    end else begin
      o.aluSrcA = 1'b1;
      o.aluSrcB = 2'b10;
      o.aluOp   = (op == SLTI) ? 2'b01 : 2'b00;
      addStep(IMM_EXEC, o, rndBit(), rndBit(), rndOp());
      o.regWrite = 1'b1;
      o.setLess  = (op == SLTI);
      addStep(IMM_WB, o, rndBit(), rndBit(), rndOp());
    end
  endfunction

  task automatic applyStimulus(input stepT s);
    @(negedge clk);
    reset     = s.rst;
    mem_ready = s.rdy;
    jr        = s.jrIn;
    opcode    = s.opIn;
    #1;
  endtask

  task automatic checkOutput(input string tag, input ctrl_state_e expSt, input outsT expOuts);
    total++;
    assert (state_o === expSt) else begin
      bad++;
      $error("[TB] FAIL %s state: observed=%0d expected=%0d", tag, state_o, expSt);
    end
    total++;
    assert (obs === expOuts) else begin
      bad++;
      $error("[TB] FAIL %s outputs in state %0d: observed=%h expected=%h", tag, expSt, obs, expOuts);
    end
  endtask

  task automatic runPlan(input string tag, input int limit);
    int n;
    n = 0;
    while (plan.size() > 0 && n < limit) begin
      stepT s;
      s = plan.pop_front();
      applyStimulus(s);
      checkOutput(tag, s.st, s.outs);
      n++;
    end
    plan.delete();
  endtask

  initial begin
    stepT       r;
    logic [5:0] rop;

    reset     = 1'b1;
    opcode    = RTYPE;
    jr        = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);

    r.st   = FETCH;
    r.outs = '0;
    r.rdy  = 1'b1;
    r.jrIn = 1'b1;
    r.opIn = LW;
    r.rst  = 1'b1;
    applyStimulus(r);
    checkOutput("reset", r.st, r.outs);

    planInstr(RTYPE, 1'b0, 0, 0);  runPlan("rtype", 1000);
    planInstr(LW,    1'b0, 3, 2);  runPlan("lwWait", 1000);
    planInstr(BEQ,   1'b0, 0, 0);  runPlan("beq", 1000);
    planInstr(BNE,   1'b0, 0, 0);  runPlan("bne", 1000);
    planInstr(RTYPE, 1'b1, 0, 0);  runPlan("jr", 1000);
    planInstr(6'b111111, 1'b0, 0, 0); runPlan("illegal", 1000);
    planInstr(J,     1'b0, 0, 0);  runPlan("jump", 1000);
    planInstr(ADDI,  1'b0, 0, 0);  runPlan("addi", 1000);
    planInstr(SLTI,  1'b0, 1, 0);  runPlan("slti", 1000);
    planInstr(SW,    1'b0, 0, 10); runPlan("swTimeout", 1000);
    planInstr(SW,    1'b0, 0, MaxWait); runPlan("swReadyWins", 1000);
    planInstr(LW,    1'b0, 0, 10); runPlan("lwTimeout", 1000);
    planInstr(RTYPE, 1'b0, 10, 0); runPlan("fetchTimeout", 1000);

    planInstr(SW, 1'b0, 0, 10);
    runPlan("preReset", 4);
    r.st   = MEM_WRITE;
    r.outs = '0;
    r.rdy  = 1'b0;
    r.jrIn = 1'b0;
    r.opIn = SW;
    r.rst  = 1'b1;
    applyStimulus(r);
    checkOutput("resetMidWrite", r.st, r.outs);
    planInstr(RTYPE, 1'b0, 0, 0);  runPlan("afterReset", 1000);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 8))
        0: rop = RTYPE;
        1: rop = LW;
        2: rop = SW;
        3: rop = BEQ;
        4: rop = BNE;
        5: rop = J;
        6: rop = ADDI;
        7: rop = SLTI;
        default: rop = rndOp();
      endcase
      planInstr(rop, rndBit(), $urandom_range(0, 6), $urandom_range(0, 6));
      runPlan("random", 1000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and mux selects, and produces ALUOp for the ALU control decoder.
- Consumes that decoder's JR flag and a memory-ready handshake.

Parameters:
- MAX_WAIT, 0, maximum cycles a memory state waits for mem_ready; 0 means unbounded.
- WAIT_W, 8, width of the wait counter; MAX_WAIT must be less than 2^WAIT_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits 31:26, valid while IR is stable
- jr  in  1  jump-register flag from ALU control decode
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- pc_write_cond_ne  out  1  PC load if not ALU zero (bne)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 1 = MDR
- set_less  out  1  writeback select: {31'b0, less flag} (slti)
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (jr)
- state_o  out  4  current state, for debug and the bench
- mem_error  out  1  one-cycle pulse on memory wait timeout
- illegal_op  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset:
  - Synchronous, active-high; the state becomes FETCH at the next edge.
  - While reset is high, every output except state_o is forced to 0.
  - Reset mid-instruction abandons that instruction; no write strobe is asserted in the reset cycle.
- Outputs are Moore, decoded from the state register, and qualified only by mem_ready and jr as listed. Every unlisted output is 0.
- FETCH:
  - mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the state then moves to DECODE, otherwise it stays.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 or 000101 -> BRANCH
    - 000010 -> JUMP
    - 001000 or 001010 -> IMM_EXEC
    - any other opcode -> FETCH, with an illegal_op pulse.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Moves to MEM_WB on mem_ready.
- MEM_WRITE: mem_write=1, i_or_d=1. Moves to FETCH on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - If jr=1: pc_write=1, pc_source=11, next state FETCH, no writeback.
  - Otherwise next state R_WB.
- R_WB: reg_write=1, reg_dst=1, alu_op=10 held. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. Asserts pc_write_cond for beq or pc_write_cond_ne for bne. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10. alu_op=00 for addi, 01 for slti. Then IMM_WB.
- IMM_WB:
  - reg_write=1, reg_dst=0, ALU selects held from IMM_EXEC.
  - set_less=1 for slti only.
  - Then FETCH.
- Opcode latching: the opcode is latched at DECODE for the rest of the instruction, so later IR changes are ignored.
- Memory wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle the state waits without mem_ready.
  - If MAX_WAIT>0 and the count reaches MAX_WAIT: pulse mem_error, deassert the request, return to FETCH with no ir/pc/reg write.
  - If mem_ready=1 in the same cycle as the timeout, mem_ready wins.
- Cycle counts with zero wait states: lw 5; R-type, sw, addi, slti 4; beq, bne, j, jr 3.
- Unused state encodings recover to FETCH on the next edge.

Decomposition:
- mips_ctrl_pkg holds:
  - the state encoding enum (4 bits)
  - opcode constants: RTYPE, LW, SW, BEQ, BNE, J, ADDI, SLTI
  - ALUOP_ADD/SUB/FUNCT
  - the alu_src_b and pc_source select constants.
- The ALU control decoder reuses the same ALUOp constants.
- One sub-module, mem_wait_timer, holds the counter and timeout compare. The FSM and output decode stay in multicycle_control.

Test Plan:
- R-type add, mem_ready always 1:
  - states FETCH, DECODE, R_EXEC, R_WB, FETCH in exactly 4 cycles
  - reg_write=1 and reg_dst=1 only in R_WB; alu_op=10 in R_EXEC.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_READ:
  - 10 cycles total
  - ir_write and pc_write each high exactly 1 cycle
  - reg_write=1 with mem_to_reg=1 in MEM_WB.
- beq then bne (opcodes 000100, 000101):
  - BRANCH asserts pc_write_cond only for beq, then pc_write_cond_ne only for bne
  - alu_op=01 and pc_source=01 in both; 3 cycles each.
- R-type with jr=1 in R_EXEC: pc_write=1, pc_source=11, no R_WB, next state FETCH; 3 cycles.
- Opcode 111111: illegal_op pulses 1 cycle at DECODE, return to FETCH, no write strobes.
- Timeout and reset:
  - MAX_WAIT=4, sw with mem_ready held 0: mem_error pulses after 4 wait cycles and the state returns to FETCH.
  - reset asserted during MEM_WRITE: all outputs 0 that cycle, FETCH the next cycle.
